cholesky_sched: RTL and testbench
=================================

// Module: cholesky_sched
// PURPOSE
//  Shares a single cholesky core between N_REQ requesters (e.g. covariance and noise-matrix square-root users).
//  - Arbitrates round-robin and latches the winning matrix.
//  - Sequences the core's enable/ready protocol and returns the captured factor tagged with the requester id.
//  - Sits between the filter-level users and one cholesky #(.SIZE(SIZE)) instance.
// PARAMETERS
//  SIZE        3     matrix order n; element = IEEE-754 double, packed row-major, (i,j) at bits [(i*SIZE+j)*64 +: 64]
//  N_REQ       2     number of requesters (2..8)
//  ENABLE_HOLD 3     cycles core_enable is held high per job (>=1)
//  TIMEOUT     4096  max WAIT cycles before abort (used only with CHOL_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    asynchronous, active-low reset
//  req_valid    in   N_REQ                per-requester job request
//  req_matrix   in   N_REQ*SIZE*SIZE*64   requester k matrix at [k*SIZE*SIZE*64 +: SIZE*SIZE*64]
//  req_ready    out  N_REQ                one-hot accept; transfer when req_valid[k] & req_ready[k]
//  resp_valid   out  1                    factor available
//  resp_factor  out  SIZE*SIZE*64         lower-triangular factor, same packing as core
//  resp_id      out  $clog2(N_REQ)        requester that owns resp_factor
//  resp_err     out  1                    job aborted by timeout (factor zeroed)
//  resp_ready   in   1                    consumer accepts response
//  busy         out  1                    high in any state but IDLE
//  core_matrix  out  SIZE*SIZE*64         to core .matrix; registered, stable for the whole job
//  core_enable  out  1                    to core .enable
//  core_factor  in   SIZE*SIZE*64         from core .factor
//  core_ready   in   1                    from core .ready (level)
// BEHAVIOUR
//  Reset (rst=0, any state, immediate):
//  - State IDLE, rr pointer=0; all outputs 0 (core_matrix, resp_factor included).
//  - Mid-job reset abandons the job silently; the core shares rst.
//  IDLE:
//  - req_ready = one-hot of the first asserted req_valid searching from the rr pointer upward (mod N_REQ); 0 if none.
//  - On transfer: latch matrix into core_matrix and id into id_q -> ENABLE next cycle.
//  ENABLE:
//  - core_enable=1 for exactly ENABLE_HOLD cycles, counted from the first ENABLE cycle -> WAIT.
//  - First cycle core_enable=1 is 2 cycles after the transfer edge.
//  WAIT:
//  - core_enable=0. Capture core_factor into resp_factor on a rising edge of core_ready (ready=1, ready_q=0) seen during ENABLE or WAIT.
//  - A level already high on entry is ignored, so a stale ready from a prior job cannot complete a new one.
//  - A rising edge seen during ENABLE is remembered; WAIT then completes on its first cycle.
//  - On capture: resp_err=0 -> DONE.
//  DONE:
//  - resp_valid=1; resp_factor/resp_id/resp_err held stable until resp_ready.
//  - On resp_valid & resp_ready: rr pointer = id_q+1 mod N_REQ -> IDLE; resp_valid drops next cycle.
//  - No new grant is issued in the handshake cycle; earliest next req_ready is the following cycle.
//  General rules:
//  - req_valid deassertion while not granted is legal; req_matrix is sampled only on transfer.
//  - Only one job is in flight; no queueing.
//  - Worst case wait per requester is N_REQ-1 jobs.
// CONFIGURATION
//  CHOL_SCHED_TIMEOUT_EN defined:
//  - 32-bit counter runs in WAIT; reaching TIMEOUT cycles without a ready edge -> DONE with resp_err=1, resp_factor=0.
//  CHOL_SCHED_TIMEOUT_EN undefined:
//  - WAIT is unbounded, resp_err is tied 0, and no counter is built.
// STRUCTURE
//  - Package chol_pkg: ELEM_W=64, function mat_w(n)=n*n*ELEM_W, state typedef {IDLE,ENABLE,WAIT,DONE}.
//  - Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot grant (combinational) and encoded index.
//  - Top holds the FSM, hold/timeout counters, ready edge register and data registers.
// TESTING
//  - Single job, 3x3 [25 15 -5;15 18 0;-5 0 11] on req 0 with the real core:
//    resp_factor l11=5, l21=3, l22=3, l31=-1, l32=1, l33=3; upper entries 0; resp_id=0.
//  - req_valid=2'b11 in the same cycle: req 0 served first, then req 1. Repeat with both held:
//    grants alternate 0,1,0,1 (rr pointer advances past the served id).
//  - Core stub raises ready 7 cycles after enable falls: core_enable high exactly ENABLE_HOLD cycles;
//    core_matrix unchanged while req_matrix toggles; factor captured on the edge cycle.
//  - resp_ready held 0 for 10 cycles in DONE: resp_valid, resp_factor and resp_id stable;
//    no req_ready while DONE.
//  - rst pulsed low during WAIT: all outputs 0 immediately, busy=0;
//    next request after release is served normally by requester 0.
//  - Stub never raises ready, CHOL_SCHED_TIMEOUT_EN, TIMEOUT=16: resp_err=1 and resp_factor=0 after 16 WAIT cycles.
//    Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/chol_pkg.sv
// chol_pkg: shared widths, matrix-size helper and FSM state encoding for the cholesky scheduler.
package chol_pkg;
  localparam int ELEM_W = 64;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0, ENABLE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  function automatic int mat_w(input int n);
    return n * n * ELEM_W;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr (mod N).
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int k;
  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    grant = '0;
    idx = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        grant = N'(1) << k;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/cholesky_sched.sv
// cholesky_sched: round-robin sharing of one cholesky core between N_REQ requesters.
// Optional abort-on-timeout in WAIT is built only when CHOL_SCHED_TIMEOUT_EN is defined.
module cholesky_sched
  import chol_pkg::*;
#(
  parameter int SIZE = 3,
  parameter int N_REQ = 2,
  parameter int ENABLE_HOLD = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*mat_w(SIZE)-1:0] req_matrix,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         resp_valid,
  output logic [mat_w(SIZE)-1:0]       resp_factor,
  output logic [$clog2(N_REQ)-1:0]     resp_id,
  output logic                         resp_err,
  input  logic                         resp_ready,
  output logic                         busy,
  output logic [mat_w(SIZE)-1:0]       core_matrix,
  output logic                         core_enable,
  input  logic [mat_w(SIZE)-1:0]       core_factor,
  input  logic                         core_ready
);
  localparam int MW = mat_w(SIZE);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(ENABLE_HOLD + 1);
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, id_q, id_d, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic [HW-1:0] hold_q, hold_d;
  logic seen_q, seen_d, ready_q, core_enable_q, core_enable_d, rise;
  logic [MW-1:0] core_matrix_q, core_matrix_d, resp_factor_q, resp_factor_d;
`ifdef CHOL_SCHED_TIMEOUT_EN
  logic resp_err_q, resp_err_d;
  logic [31:0] tmo_q, tmo_d;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (.req(req_valid), .ptr(rr_q), .grant(gnt), .idx(gnt_idx));

  // A ready level left over from the previous job never counts; only a fresh rise does.
  assign rise = core_ready & ~ready_q;
  assign req_ready = (rst && state_q == IDLE) ? gnt : '0;
  assign resp_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign resp_id = id_q;
  assign resp_factor = resp_factor_q;
  assign core_matrix = core_matrix_q;
  assign core_enable = core_enable_q;

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    hold_d = hold_q;
    seen_d = seen_q;
    core_matrix_d = core_matrix_q;
    core_enable_d = 1'b0;
    resp_factor_d = resp_factor_q;
`ifdef CHOL_SCHED_TIMEOUT_EN
    resp_err_d = resp_err_q;
    tmo_d = tmo_q;
`endif
    if (state_q == IDLE && |req_ready) begin
      state_d = ENABLE;
      id_d = gnt_idx;
      hold_d = '0;
      seen_d = 1'b0;
      core_matrix_d = req_matrix[int'(gnt_idx)*MW +: MW];
`ifdef CHOL_SCHED_TIMEOUT_EN
      tmo_d = '0;
`endif
    end
    if (state_q == ENABLE) begin
      core_enable_d = hold_q != HW'(ENABLE_HOLD);
      hold_d = core_enable_d ? hold_q + 1'b1 : hold_q;
      state_d = core_enable_d ? ENABLE : WAIT;
      if (rise) begin
        seen_d = 1'b1;
        resp_factor_d = core_factor;
      end
    end
    if (state_q == WAIT) begin
      if (rise) resp_factor_d = core_factor;
      if (rise || seen_q) begin
        state_d = DONE;
`ifdef CHOL_SCHED_TIMEOUT_EN
        resp_err_d = 1'b0;
`endif
      end
`ifdef CHOL_SCHED_TIMEOUT_EN
      else if (tmo_q == 32'(TIMEOUT - 1)) begin
        state_d = DONE;
        resp_err_d = 1'b1;
        resp_factor_d = '0;
      end
      tmo_d = tmo_q + 32'd1;
`endif
    end
    if (state_q == DONE && resp_ready) begin
      state_d = IDLE;
      rr_d = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      hold_q <= '0;
      seen_q <= 1'b0;
      ready_q <= 1'b0;
      core_matrix_q <= '0;
      core_enable_q <= 1'b0;
      resp_factor_q <= '0;
`ifdef CHOL_SCHED_TIMEOUT_EN
      resp_err_q <= 1'b0;
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      hold_q <= hold_d;
      seen_q <= seen_d;
      ready_q <= core_ready;
      core_matrix_q <= core_matrix_d;
      core_enable_q <= core_enable_d;
      resp_factor_q <= resp_factor_d;
`ifdef CHOL_SCHED_TIMEOUT_EN
      resp_err_q <= resp_err_d;
      tmo_q <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_cholesky_sched.sv
// tb_cholesky_sched: directed vector table plus hand-written job sequences with a bench-side core stub.
module tb_cholesky_sched;
  localparam int SIZE = 3;
  localparam int HOLD = 3;
  localparam int MW = SIZE * SIZE * 64;
  logic clk = 1'b0;
  logic rst, resp_ready, core_enable, core_ready, resp_valid, resp_err, busy, resp_id;
  logic [1:0] req_valid, req_ready;
  logic [2*MW-1:0] req_matrix;
  logic [MW-1:0] resp_factor, core_matrix, core_factor, mat_a, mat_l, mat_o;
  int total = 0;
  int passes = 0;
  int n;
  typedef struct {
    logic [1:0] valid;
    logic [1:0] exp_rdy;
    int delay;
    bit early;
  } vec_t;
  vec_t tbl[7];
  real a[9];
  real l[9];

  always #5 clk = ~clk;

  cholesky_sched #(.SIZE(SIZE), .N_REQ(2), .ENABLE_HOLD(HOLD), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_matrix(req_matrix), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_factor(resp_factor), .resp_id(resp_id), .resp_err(resp_err),
    .resp_ready(resp_ready), .busy(busy), .core_matrix(core_matrix), .core_enable(core_enable),
    .core_factor(core_factor), .core_ready(core_ready)
  );

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_job(input logic [1:0] v, input logic [1:0] exp_rdy, input logic [MW-1:0] m0,
                         input logic [MW-1:0] m1, input logic [MW-1:0] fac, input int delay,
                         input bit early, input int hold);
    logic [MW-1:0] exp_m;
    logic id;
    int c;
    id = exp_rdy[1];
    exp_m = id ? m1 : m0;
    @(negedge clk);
    req_matrix = {m1, m0};
    req_valid = v;
    #1;
    chk("grant", MW'(req_ready), MW'(exp_rdy));
    @(negedge clk);
    req_valid = 2'b00;
    req_matrix = ~req_matrix;
    chk("busy", MW'(busy), 1);
    chk("enable_not_yet", MW'(core_enable), 0);
    @(negedge clk);
    chk("enable_start", MW'(core_enable), 1);
    c = 0;
    while (core_enable && c < 20) begin
      chk("core_matrix_hold", core_matrix, exp_m);
      req_matrix = ~req_matrix;
      if (early && c == 0) core_ready = 1'b0;
      if (early && c == 1) begin
        core_ready = 1'b1;
        core_factor = fac;
      end
      if (early && c == 2) core_factor = ~fac;
      c++;
      @(negedge clk);
    end
    chk("enable_len", MW'(c), MW'(HOLD));
    if (early) begin
      chk("early_wait", MW'(resp_valid), 0);
      @(negedge clk);
    end else begin
      repeat (delay) begin
        chk("stale_ready", MW'(resp_valid), 0);
        @(negedge clk);
      end
      core_ready = 1'b0;
      @(negedge clk);
      core_ready = 1'b1;
      core_factor = fac;
      chk("pre_edge", MW'(resp_valid), 0);
      @(negedge clk);
      core_factor = ~fac;
    end
    chk("resp_valid", MW'(resp_valid), 1);
    chk("resp_factor", resp_factor, fac);
    chk("resp_id", MW'(resp_id), MW'(id));
    chk("resp_err", MW'(resp_err), 0);
    chk("core_matrix_done", core_matrix, exp_m);
    req_valid = 2'b11;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk("done_no_grant", MW'(req_ready), 0);
      chk("done_valid", MW'(resp_valid), 1);
      chk("done_factor", resp_factor, fac);
      chk("done_id", MW'(resp_id), MW'(id));
    end
    resp_ready = 1'b1;
    #1;
    chk("hs_no_grant", MW'(req_ready), 0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("valid_drop", MW'(resp_valid), 0);
    chk("idle", MW'(busy), 0);
    chk("rr_next", MW'(req_ready), MW'(id ? 2'b01 : 2'b10));
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    a = '{25.0, 15.0, -5.0, 15.0, 18.0, 0.0, -5.0, 0.0, 11.0};
    l = '{5.0, 0.0, 0.0, 3.0, 3.0, 0.0, -1.0, 1.0, 3.0};
    for (int i = 0; i < 9; i++) begin
      mat_a[i*64 +: 64] = $realtobits(a[i]);
      mat_l[i*64 +: 64] = $realtobits(l[i]);
      mat_o[i*64 +: 64] = $realtobits(1.0);
    end
    tbl[0] = '{2'b11, 2'b01, 2, 1'b0};
    tbl[1] = '{2'b11, 2'b10, 0, 1'b1};
    tbl[2] = '{2'b11, 2'b01, 0, 1'b0};
    tbl[3] = '{2'b11, 2'b10, 3, 1'b0};
    tbl[4] = '{2'b10, 2'b10, 1, 1'b0};
    tbl[5] = '{2'b01, 2'b01, 0, 1'b1};
    tbl[6] = '{2'b01, 2'b01, 1, 1'b0};
    rst = 1'b0;
    req_valid = 2'b00;
    req_matrix = '0;
    resp_ready = 1'b0;
    core_ready = 1'b0;
    core_factor = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", MW'(req_ready), 0);
    chk("rst_busy", MW'(busy), 0);
    chk("rst_resp_valid", MW'(resp_valid), 0);
    chk("rst_core_enable", MW'(core_enable), 0);
    chk("rst_core_matrix", core_matrix, '0);
    chk("rst_resp_factor", resp_factor, '0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    run_job(2'b01, 2'b01, mat_a, mat_o, mat_l, 6, 1'b0, 10);
    chk("l33", MW'(resp_factor[8*64 +: 64]), MW'($realtobits(3.0)));
    chk("l12_zero", MW'(resp_factor[1*64 +: 64]), 0);
    @(negedge clk);
    req_matrix = {mat_o, mat_a};
    req_valid = 2'b11;
    #1;
    chk("rr_after_job", MW'(req_ready), MW'(2'b10));
    @(negedge clk);
    req_valid = 2'b00;
    repeat (HOLD + 2) @(negedge clk);
    chk("wait_busy", MW'(busy), 1);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_busy", MW'(busy), 0);
    chk("mid_rst_req_ready", MW'(req_ready), 0);
    chk("mid_rst_core_matrix", core_matrix, '0);
    chk("mid_rst_resp_factor", resp_factor, '0);
    chk("mid_rst_enable", MW'(core_enable), 0);
    chk("mid_rst_resp_valid", MW'(resp_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 7; i++)
      run_job(tbl[i].valid, tbl[i].exp_rdy, {9{64'hA000 + 64'(i)}}, {9{64'hB000 + 64'(i)}},
              {9{64'h0101_0101_0101_0101 * 64'(i + 1)}}, tbl[i].delay, tbl[i].early, 2);
    core_ready = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (HOLD + 1) @(negedge clk);
`ifdef CHOL_SCHED_TIMEOUT_EN
    n = 0;
    while (!resp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", MW'(n), 16);
    chk("timeout_err", MW'(resp_err), 1);
    chk("timeout_factor", resp_factor, '0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("timeout_idle", MW'(busy), 0);
`else
    repeat (40) @(negedge clk);
    chk("no_timeout_busy", MW'(busy), 1);
    chk("no_timeout_valid", MW'(resp_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
